// File: rtl/item_inv_pkg.sv
// ============================================================================
// Module   : item_inv_pkg
// Brief    : Shared FSM state type, default widths and entry packing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package item_inv_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam int DEF_MAX_ITEMS  = 1024;
  localparam int DEF_PRICE_W    = 16;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_SOLD_W     = 8;
  localparam int DEF_LOW_THRESH = 2;

  // Packs {sold, count, price} MSB to LSB; fields must arrive zero-extended.
  function automatic logic [63:0] pack_entry(input logic [63:0] sold,
                                             input logic [63:0] count,
                                             input logic [63:0] price,
                                             input int          cnt_w,
                                             input int          price_w);
    return (sold << (cnt_w + price_w)) | (count << price_w) | price;
  endfunction

endpackage

`default_nettype wire

// File: rtl/item_inventory_ctrl_if.sv
// ============================================================================
// Module   : item_inventory_ctrl_if
// Brief    : Config, dispense and read bus of the item inventory controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface item_inventory_ctrl_if #(
  parameter int AW      = 10,
  parameter int PRICE_W = 16,
  parameter int CNT_W   = 8,
  parameter int SOLD_W  = 8
);
  logic               init_busy;
  logic               cfg_we;
  logic               cfg_ready;
  logic [AW-1:0]      cfg_addr;
  logic [SOLD_W-1:0]  cfg_sold;
  logic [CNT_W-1:0]   cfg_count;
  logic [PRICE_W-1:0] cfg_price;
  logic               disp_req;
  logic [AW-1:0]      disp_idx;
  logic               disp_ack;
  logic               disp_ok;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic               rd_valid;
  logic [PRICE_W-1:0] rd_price;
  logic [CNT_W-1:0]   rd_count;
  logic [SOLD_W-1:0]  rd_sold;
  logic               low_stock;
  logic [AW-1:0]      low_stock_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_sold, cfg_count, cfg_price,
    output disp_req, disp_idx, rd_en, rd_addr,
    input  init_busy, cfg_ready, disp_ack, disp_ok, rd_valid,
    input  rd_price, rd_count, rd_sold, low_stock, low_stock_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sold, cfg_count, cfg_price,
    input  disp_req, disp_idx, rd_en, rd_addr,
    output init_busy, cfg_ready, disp_ack, disp_ok, rd_valid,
    output rd_price, rd_count, rd_sold, low_stock, low_stock_idx
  );
endinterface

`default_nettype wire

// File: rtl/item_inv_ram.sv
// ============================================================================
// Module   : item_inv_ram
// Brief    : Entry storage: one write port, registered external and RMW reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module item_inv_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          rmw_en,
  input  logic [AW-1:0] rmw_addr,
  output logic [DW-1:0] rmw_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_rmw_data;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Only the visible read register is reset so the port reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rmw_en) begin
      r_rmw_data <= r_mem[rmw_addr];
    end
  end

  assign rd_data  = r_rd_data;
  assign rmw_data = r_rmw_data;

endmodule

`default_nettype wire

// File: rtl/item_inventory_ctrl.sv
// ============================================================================
// Module   : item_inventory_ctrl
// Brief    : Item price/stock/sales table with clear sweep and atomic dispense.
//            Optional low-stock reporting: ITEM_INV_LOW_STOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module item_inventory_ctrl
  import item_inv_pkg::*;
#(
  parameter int MAX_ITEMS  = DEF_MAX_ITEMS,
  parameter int PRICE_W    = DEF_PRICE_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SOLD_W     = DEF_SOLD_W,
  parameter int LOW_THRESH = DEF_LOW_THRESH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  item_inventory_ctrl_if.slave bus
);

  localparam int AW      = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam int ENTRY_W = SOLD_W + CNT_W + PRICE_W;

  state_t              r_state;
  state_t              w_next;
  logic [AW-1:0]       r_ptr;
  logic [AW-1:0]       r_idx;
  logic                r_ack;
  logic                r_ok;
  logic                r_rd_valid;

  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [ENTRY_W-1:0]  w_wdata;
  logic                w_rmw_en;
  logic                w_latch;
  logic                w_ack_set;
  logic                w_ok;
  logic                w_rd_en;
  logic [ENTRY_W-1:0]  w_rd_data;
  logic [ENTRY_W-1:0]  w_rmw_data;

  logic                w_sweep_last;
  logic                w_cfg_in_range;
  logic                w_idx_in_range;
  logic [SOLD_W-1:0]   w_cur_sold;
  logic [CNT_W-1:0]    w_cur_count;
  logic [PRICE_W-1:0]  w_cur_price;
  logic [SOLD_W-1:0]   w_new_sold;
  logic [CNT_W-1:0]    w_new_count;

  assign w_sweep_last   = (r_ptr == AW'(MAX_ITEMS - 1));
  assign w_cfg_in_range = ({1'b0, bus.cfg_addr} < (AW+1)'(MAX_ITEMS));
  assign w_idx_in_range = ({1'b0, r_idx} < (AW+1)'(MAX_ITEMS));

  assign w_cur_sold  = w_rmw_data[ENTRY_W-1 -: SOLD_W];
  assign w_cur_count = w_rmw_data[PRICE_W +: CNT_W];
  assign w_cur_price = w_rmw_data[0 +: PRICE_W];
  assign w_new_count = w_cur_count - 1'b1;
  assign w_new_sold  = (&w_cur_sold) ? w_cur_sold : w_cur_sold + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    w_wdata   = '0;
    w_rmw_en  = 1'b0;
    w_latch   = 1'b0;
    w_ack_set = 1'b0;
    w_ok      = 1'b0;
    case (r_state)
      INIT: begin
        w_we = 1'b1;
        if (w_sweep_last) begin
          w_next = IDLE;
        end
      end
      IDLE: begin
        if (bus.cfg_we) begin
          w_we    = w_cfg_in_range;
          w_waddr = bus.cfg_addr;
          w_wdata = ENTRY_W'(pack_entry(64'(bus.cfg_sold), 64'(bus.cfg_count),
                                        64'(bus.cfg_price), CNT_W, PRICE_W));
        end else if (bus.disp_req && !r_ack) begin
          w_latch = 1'b1;
          w_next  = RD;
        end
      end
      RD: begin
        w_rmw_en = 1'b1;
        w_next   = WR;
      end
      WR: begin
        w_ack_set = 1'b1;
        w_next    = IDLE;
        if (w_idx_in_range && (w_cur_count != '0)) begin
          w_ok    = 1'b1;
          w_we    = 1'b1;
          w_waddr = r_idx;
          w_wdata = ENTRY_W'(pack_entry(64'(w_new_sold), 64'(w_new_count),
                                        64'(w_cur_price), CNT_W, PRICE_W));
        end
      end
      default: w_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_idx      <= '0;
      r_ack      <= 1'b0;
      r_ok       <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_ptr <= w_sweep_last ? '0 : r_ptr + 1'b1;
      end
      if (w_latch) begin
        r_idx <= bus.disp_idx;
      end
      r_ack      <= w_ack_set;
      r_ok       <= w_ok;
      r_rd_valid <= w_rd_en;
    end
  end

  assign w_rd_en = bus.rd_en && (r_state != INIT);

  item_inv_ram #(
    .DEPTH (MAX_ITEMS),
    .AW    (AW),
    .DW    (ENTRY_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (w_we),
    .waddr    (w_waddr),
    .wdata    (w_wdata),
    .rd_en    (w_rd_en),
    .rd_addr  (bus.rd_addr),
    .rd_data  (w_rd_data),
    .rmw_en   (w_rmw_en),
    .rmw_addr (r_idx),
    .rmw_data (w_rmw_data)
  );

  assign bus.init_busy = (r_state == INIT);
  assign bus.cfg_ready = (r_state == IDLE);
  assign bus.disp_ack  = r_ack;
  assign bus.disp_ok   = r_ok;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_sold   = w_rd_data[ENTRY_W-1 -: SOLD_W];
  assign bus.rd_count  = w_rd_data[PRICE_W +: CNT_W];
  assign bus.rd_price  = w_rd_data[0 +: PRICE_W];

`ifdef ITEM_INV_LOW_STOCK_EN
  logic          r_low;
  logic [AW-1:0] r_low_idx;
  logic          w_low_hit;

  assign w_low_hit = w_ok && (w_new_count <= CNT_W'(LOW_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low     <= 1'b0;
      r_low_idx <= '0;
    end else begin
      r_low <= w_low_hit;
      if (w_low_hit) begin
        r_low_idx <= r_idx;
      end
    end
  end

  assign bus.low_stock     = r_low;
  assign bus.low_stock_idx = r_low_idx;
`else
  // Threshold only matters when reporting is built in; this folds to 0.
  assign bus.low_stock     = 1'b0 & (LOW_THRESH >= 0);
  assign bus.low_stock_idx = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_item_inventory_ctrl.sv
// ============================================================================
// Module   : tb_item_inventory_ctrl
// Brief    : Randomized self-checking bench against a table-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_item_inventory_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int PW = 16;
  localparam int CW = 8;
  localparam int SW = 8;
  localparam int TH = 2;
`ifdef ITEM_INV_LOW_STOCK_EN
  localparam bit LS_EN = 1'b1;
`else
  localparam bit LS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  item_inventory_ctrl_if #(.AW(AW), .PRICE_W(PW), .CNT_W(CW), .SOLD_W(SW)) bus ();

  item_inventory_ctrl #(
    .MAX_ITEMS  (N),
    .PRICE_W    (PW),
    .CNT_W      (CW),
    .SOLD_W     (SW),
    .LOW_THRESH (TH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_price [N];
  int m_count [N];
  int m_sold  [N];
  int m_low_idx;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_price[i] = 0;
      m_count[i] = 0;
      m_sold[i]  = 0;
    end
    m_low_idx = 0;
  endtask

  task automatic sweep_check();
    int cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("sweep_len", cnt, N);
    check("ready_after_sweep", bus.cfg_ready, 1);
  endtask

  task automatic do_cfg(input int addr, input int sold, input int cnt, input int price);
    check("cfg_ready", bus.cfg_ready, 1);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = AW'(addr);
    bus.cfg_sold  = SW'(sold);
    bus.cfg_count = CW'(cnt);
    bus.cfg_price = PW'(price);
    tick();
    bus.cfg_we = 1'b0;
    m_sold[addr]  = sold;
    m_count[addr] = cnt;
    m_price[addr] = price;
  endtask

  task automatic do_read(input int addr);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(addr);
    tick();
    bus.rd_en = 1'b0;
    check("rd_valid", bus.rd_valid, 1);
    check("rd_price", bus.rd_price, m_price[addr]);
    check("rd_count", bus.rd_count, m_count[addr]);
    check("rd_sold",  bus.rd_sold,  m_sold[addr]);
  endtask

  // Called in the ack cycle: compare against the table, then apply the sale.
  task automatic check_ack(input int idx);
    bit exp_ok;
    bit exp_ls;
    exp_ok = (m_count[idx] != 0);
    check("disp_ack", bus.disp_ack, 1);
    check("disp_ok",  bus.disp_ok,  exp_ok);
    if (exp_ok) begin
      m_count[idx] = m_count[idx] - 1;
      if (m_sold[idx] < 255) m_sold[idx] = m_sold[idx] + 1;
    end
    exp_ls = LS_EN && exp_ok && (m_count[idx] <= TH);
    if (exp_ls) m_low_idx = idx;
    check("low_stock",     bus.low_stock,     exp_ls);
    check("low_stock_idx", bus.low_stock_idx, m_low_idx);
    bus.disp_req = 1'b0;
    tick();
    check("ack_pulse_end", bus.disp_ack, 0);
  endtask

  task automatic do_disp(input int idx, input int exp_lat);
    int lat = 0;
    bus.disp_req = 1'b1;
    bus.disp_idx = AW'(idx);
    while (bus.disp_ack !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) bus.cfg_we = 1'b0;
    end
    check("disp_latency", lat, exp_lat);
    check_ack(idx);
  endtask

  initial begin
    int acks;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_sold = 0; bus.cfg_count = 0;
    bus.cfg_price = 0; bus.disp_req = 0; bus.disp_idx = 0; bus.rd_en = 0;
    bus.rd_addr = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_init_busy", bus.init_busy, 1);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_disp_ack",  bus.disp_ack,  0);
    check("rst_rd_valid",  bus.rd_valid,  0);
    check("rst_low_stock", bus.low_stock, 0);
    rst_n = 1'b1;
    sweep_check();
    do_read(5);

    do_cfg(3, 0, 5, 250);
    do_read(3);
    do_disp(3, 3);
    do_read(3);
    do_disp(3, 3);
    do_disp(3, 3);
    do_read(3);

    do_disp(4, 3);
    do_read(4);
    do_cfg(1, 255, 1, 77);
    do_disp(1, 3);
    do_read(1);

    // Config and dispense in the same cycle: config wins, dispense slips one.
    bus.cfg_we = 1'b1; bus.cfg_addr = 6; bus.cfg_sold = 0; bus.cfg_count = 1;
    bus.cfg_price = 9;
    m_sold[6] = 0; m_count[6] = 1; m_price[6] = 9;
    do_disp(6, 4);
    do_read(6);

    // Config write while the dispense is in RD must be dropped.
    bus.disp_req = 1'b1; bus.disp_idx = 3;
    tick();
    check("ready_in_rd", bus.cfg_ready, 0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2; bus.cfg_sold = 7; bus.cfg_count = 7;
    bus.cfg_price = 7;
    tick();
    bus.cfg_we = 1'b0;
    check("ready_in_wr", bus.cfg_ready, 0);
    tick();
    check_ack(3);
    do_read(2);

    // Read-before-write on the same address and edge.
    bus.cfg_we = 1'b1; bus.cfg_addr = 3; bus.cfg_sold = 11; bus.cfg_count = 12;
    bus.cfg_price = 1300;
    bus.rd_en = 1'b1; bus.rd_addr = 3;
    tick();
    bus.cfg_we = 1'b0; bus.rd_en = 1'b0;
    check("rbw_old_count", bus.rd_count, m_count[3]);
    check("rbw_old_price", bus.rd_price, m_price[3]);
    m_sold[3] = 11; m_count[3] = 12; m_price[3] = 1300;
    do_read(3);
    tick();
    check("rd_valid_drop", bus.rd_valid, 0);
    check("rd_data_held",  bus.rd_price, 1300);

    for (int k = 0; k < 60; k++) begin
      int op;
      int a;
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, N - 1);
      case (op)
        0: begin
          int s;
          s = $urandom_range(0, 3);
          do_cfg(a, (s == 0) ? 255 : (s == 1) ? 254 : $urandom_range(0, 255),
                 $urandom_range(0, 3), $urandom_range(0, 65535));
        end
        1: do_disp(a, 3);
        default: do_read(a);
      endcase
    end

    // Reset during WR: no ack, outputs clear at once, sweep restarts.
    bus.disp_req = 1'b1; bus.disp_idx = 3;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_init_busy", bus.init_busy, 1);
    check("mid_disp_ack",  bus.disp_ack,  0);
    check("mid_disp_ok",   bus.disp_ok,   0);
    check("mid_rd_valid",  bus.rd_valid,  0);
    check("mid_cfg_ready", bus.cfg_ready, 0);
    check("mid_rd_price",  bus.rd_price,  0);
    check("mid_low_idx",   bus.low_stock_idx, 0);
    bus.disp_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.disp_ack === 1'b1) acks++;
    end
    rst_n = 1'b1;
    model_clear();
    sweep_check();
    check("mid_no_ack", acks, 0);
    do_read(3);
    do_read(0);
    do_read(7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/item_inventory_ctrl.md
# item_inventory_ctrl

Parametrised, reset-safe successor to the vending item memory. It stores per-item price, stock count and sales count, and clears the whole table after reset. Dispenses are performed as an atomic read-modify-write with a request/acknowledge handshake that reports accept or reject. A registered read port runs independently of the update path. The block sits between the vending control FSM (dispense, read) and the operator configuration interface (cfg).

## Interface

Parameters:
- MAX_ITEMS, 1024: number of item entries; AW = $clog2(MAX_ITEMS).
- PRICE_W, 16: price field width.
- CNT_W, 8: stock-count field width.
- SOLD_W, 8: sales-count field width.
- LOW_THRESH, 2: low-stock threshold, CNT_W bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_busy  out  1  high while the post-reset clear sweep runs.
- cfg_we  in  1  config write strobe; honoured only when cfg_ready=1.
- cfg_ready  out  1  high when a config write is accepted this cycle.
- cfg_addr  in  AW  entry to write.
- cfg_sold / cfg_count / cfg_price  in  SOLD_W / CNT_W / PRICE_W  entry fields.
- disp_req  in  1  dispense request; held until disp_ack.
- disp_idx  in  AW  item to dispense; stable while disp_req is high.
- disp_ack  out  1  one-cycle completion pulse.
- disp_ok  out  1  valid with disp_ack: 1 = dispensed, 0 = rejected.
- rd_en / rd_addr  in  1 / AW  read request.
- rd_valid  out  1  read data valid.
- rd_price / rd_count / rd_sold  out  PRICE_W / CNT_W / SOLD_W  read data.
- low_stock  out  1  pulse with disp_ack (see Configuration).
- low_stock_idx  out  AW  index that triggered low_stock.

## Operation

- FSM states: INIT, IDLE, RD, WR.
- Reset value: state=INIT, sweep pointer=0. All outputs are 0 except init_busy=1.
- INIT: writes entry {0,0,0} to one address per cycle, 0..MAX_ITEMS-1. Moves to IDLE after the last write. During INIT, cfg_ready=0, rd_valid=0 and disp_req is ignored.
- IDLE: cfg_ready=1.
  - cfg_we=1 writes the entry and the FSM stays in IDLE. Config has priority: a simultaneous disp_req waits.
  - Otherwise, disp_req=1 with disp_ack=0 latches disp_idx and moves to RD.
- RD: the entry is registered. Moves to WR.
- WR: computes and writes back the entry, then returns to IDLE with disp_ack=1 for one cycle.
  - Stock count 0, or disp_idx >= MAX_ITEMS: reject. Entry is unchanged and disp_ok=0.
  - Otherwise: count-1, sold+1 saturating at all-ones, disp_ok=1.
- cfg_ready=0 in RD and WR; cfg_we is ignored there, not queued.
- cfg_addr >= MAX_ITEMS: write is dropped.
- Reset asserted mid-dispense: the transaction is lost, no ack is issued, and the sweep restarts from 0.

## Timing

- Dispense: disp_req sampled at edge N in IDLE → RD after N, WR after N+1, disp_ack/disp_ok high in the cycle after edge N+2.
- Latency is 3 cycles; back-to-back dispenses are spaced 4 cycles apart.
- The requester may drop or change disp_req in the ack cycle. Any request seen while disp_ack=1 is ignored.
- Read: rd_en at edge N → rd_valid and data in the cycle after N.
  - Data is held when rd_en=0; rd_valid follows rd_en.
  - Read-before-write: a read of an address written at the same edge returns the old value.
- A config write is visible to a read issued one edge later.
- Sweep duration: MAX_ITEMS cycles after rst_n deasserts.

## Configuration

- ITEM_INV_LOW_STOCK_EN defined: low_stock=1 with disp_ack when disp_ok=1 and the new count <= LOW_THRESH. low_stock_idx carries that index and holds until the next such event.
- ITEM_INV_LOW_STOCK_EN undefined: low_stock and low_stock_idx are tied to 0. No comparator logic is generated.
- The ports exist in both builds.

## Structure

- Package item_inv_pkg holds:
  - the FSM state enum {INIT, IDLE, RD, WR};
  - default width localparams;
  - the entry-packing function that orders fields sold, count, price from MSB to LSB.
- Sub-module item_inv_ram: simple dual-port storage, one write port and one registered read port for the external read.
  - No reset on the array.
  - The RMW read uses a second read port of the same array, also in item_inv_ram.
- The FSM, sweep counter, arithmetic and low-stock logic live in item_inventory_ctrl.

## Test plan

- Reset then sweep: with MAX_ITEMS=8, init_busy is high for 8 cycles. Reading idx 5 afterwards gives price 0, count 0, sold 0.
- Config and read: write idx 3 = {sold 0, count 5, price 250}. Read idx 3 on the next cycle → 250/5/0 with a 1-cycle latency.
- Dispense accept: dispense idx 3 → disp_ack 3 cycles later with disp_ok=1. The read then returns count 4, sold 1. With the macro on and count reaching 2, low_stock=1 and low_stock_idx=3.
- Reject and saturation:
  - idx 4 with count 0 → disp_ok=0 and the entry is unchanged.
  - Sold=255 with count 1 → sold stays 255, count 0, disp_ok=1.
- Config/dispense collision: cfg_we and disp_req in the same IDLE cycle → config is written first and the dispense is acked 1 cycle later than usual. cfg_we during RD is dropped while cfg_ready=0.
- Reset mid-op: pull rst_n low during WR → no disp_ack, outputs are 0 and init_busy=1 immediately, and the sweep restarts at 0.
